// File: rtl/jk_pkg.sv
// ============================================================================
//  Module      : jk_pkg
//  Description : Shared mode encoding for the JK register/counter slice.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package jk_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t MODE_JK = 2'b00;
  localparam jk_mode_t MODE_UP = 2'b01;
  localparam jk_mode_t MODE_DN = 2'b10;
  localparam jk_mode_t MODE_LD = 2'b11;

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
//  Module      : jk_cell
//  Description : Single JK flip-flop with clock enable and async reset to RV.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module jk_cell #(
  parameter logic RV = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q <= RV;
    end else if (ce) begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_reg_counter.sv
// ============================================================================
//  Module      : jk_reg_counter
//  Description : WIDTH JK cells steered as JK register, up/down counter or
//                parallel load, with terminal-count and change flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module jk_reg_counter
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  jk_mode_t         mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             tc,
  output logic             chg
);

  logic [WIDTH-1:0] w_up_t;
  logic [WIDTH-1:0] w_dn_t;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;
  logic             r_chg;

  // Toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
  assign w_up_t[0] = 1'b1;
  assign w_dn_t[0] = 1'b1;

  generate
    for (genvar i = 1; i < WIDTH; i++) begin : g_tchain
      assign w_up_t[i] = &Q[i-1:0];
      assign w_dn_t[i] = &(~Q[i-1:0]);
    end
  endgenerate

  always_comb begin
    w_j = '0;
    w_k = '0;
    case (mode)
      MODE_JK: begin
        w_j = J;
        w_k = K;
      end
      MODE_UP: begin
        w_j = w_up_t;
        w_k = w_up_t;
      end
      MODE_DN: begin
        w_j = w_dn_t;
        w_k = w_dn_t;
      end
      MODE_LD: begin
        w_j = d;
        w_k = ~d;
      end
    endcase
  end

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell #(
        .RV (RST_VAL[i])
      ) u_cell (
        .clk (clk),
        .rst (rst),
        .ce  (en),
        .J   (w_j[i]),
        .K   (w_k[i]),
        .Q   (Q[i])
      );
    end
  endgenerate

  // Characteristic equation of the cells, used only to detect a change.
  assign w_q_next = (w_j & ~Q) | (~w_k & Q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= en & (w_q_next != Q);
    end
  end

  assign chg  = r_chg;
  assign Qbar = ~Q;
  assign tc   = en & (((mode == MODE_UP) & (&Q)) | ((mode == MODE_DN) & ~(|Q)));

endmodule

`default_nettype wire

// File: tb/tb_jk_reg_counter.sv
// ============================================================================
//  Module      : tb_jk_reg_counter
//  Description : Directed scoreboard bench for jk_reg_counter and a cascade.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jk_reg_counter;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  jk_mode_t   mode;
  logic [3:0] J, K, d;
  logic [3:0] Q, Qbar;
  logic       tc, chg;

  logic       c_rst;
  logic       one = 1'b1;
  jk_mode_t   up_mode = MODE_UP;
  logic [3:0] zero4 = 4'b0000;
  logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
  logic       lo_tc, lo_chg, hi_tc, hi_chg;

  jk_reg_counter #(.WIDTH(4), .RST_VAL(4'b1010)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K), .d(d),
    .Q(Q), .Qbar(Qbar), .tc(tc), .chg(chg)
  );

  jk_reg_counter #(.WIDTH(4), .RST_VAL(4'b0000)) u_lo (
    .clk(clk), .rst(c_rst), .en(one), .mode(up_mode), .J(zero4), .K(zero4), .d(zero4),
    .Q(lo_q), .Qbar(lo_qb), .tc(lo_tc), .chg(lo_chg)
  );

  jk_reg_counter #(.WIDTH(4), .RST_VAL(4'b0000)) u_hi (
    .clk(clk), .rst(c_rst), .en(lo_tc), .mode(up_mode), .J(zero4), .K(zero4), .d(zero4),
    .Q(hi_q), .Qbar(hi_qb), .tc(hi_tc), .chg(hi_chg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         casc;
    int         cyc;
    logic [7:0] q;
    logic       tc;
    logic       chg;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Monitor: each entry is tagged with the cycle whose falling edge shows it.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: missed at cycle %0d expected cycle %0d", e.name, cyc, e.cyc);
      end else if (e.casc) begin
        chk({e.name, ".count"}, {hi_q, lo_q}, e.q);
      end else begin
        chk({e.name, ".Q"},    {4'b0, Q},    e.q);
        chk({e.name, ".Qbar"}, {4'b0, Qbar}, {4'b0, ~e.q[3:0]});
        chk({e.name, ".tc"},   {7'b0, tc},   {7'b0, e.tc});
        chk({e.name, ".chg"},  {7'b0, chg},  {7'b0, e.chg});
      end
    end
  end

  // Called just after a falling edge: expectation is for the next falling edge.
  task automatic expect_next(string nm, logic [3:0] q, logic t, logic c);
    exp_t e;
    e.casc = 1'b0; e.cyc = cyc + 1; e.q = {4'b0, q}; e.tc = t; e.chg = c; e.name = nm;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    exp_t e;
    rst = 1'b1; en = 1'b0; mode = MODE_JK; J = '0; K = '0; d = '0; c_rst = 1'b1;
    @(negedge clk); #1;
    expect_next("reset", 4'b1010, 1'b0, 1'b0);

    rst = 1'b0; en = 1'b1; mode = MODE_JK; J = 4'b0101; K = 4'b1010;
    expect_next("jk_setclr", 4'b0101, 1'b0, 1'b1);
    J = 4'b1111; K = 4'b1111;
    expect_next("jk_tog1", 4'b1010, 1'b0, 1'b1);
    expect_next("jk_tog2", 4'b0101, 1'b0, 1'b1);
    J = 4'b0000; K = 4'b0000;
    expect_next("jk_hold", 4'b0101, 1'b0, 1'b0);
    J = 4'b0110; K = 4'b0011;
    expect_next("jk_mixed", 4'b0110, 1'b0, 1'b1);

    mode = MODE_LD; d = 4'b1110; J = 4'b1111; K = 4'b1111;
    expect_next("load_e", 4'b1110, 1'b0, 1'b1);
    mode = MODE_UP;
    expect_next("up_f", 4'b1111, 1'b1, 1'b1);
    expect_next("up_wrap", 4'b0000, 1'b0, 1'b1);
    expect_next("up_1", 4'b0001, 1'b0, 1'b1);

    mode = MODE_LD; d = 4'b0001;
    expect_next("load_same", 4'b0001, 1'b0, 1'b0);
    mode = MODE_DN;
    expect_next("dn_0", 4'b0000, 1'b1, 1'b1);
    expect_next("dn_wrap", 4'b1111, 1'b0, 1'b1);
    expect_next("dn_e", 4'b1110, 1'b0, 1'b1);

    mode = MODE_UP;
    expect_next("up_to_f", 4'b1111, 1'b1, 1'b1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) expect_next("en_off", 4'b1111, 1'b0, 1'b0);
    en = 1'b1; mode = MODE_JK; J = 4'b0000; K = 4'b0000;
    expect_next("jk_hold_f", 4'b1111, 1'b0, 1'b0);

    mode = MODE_LD; d = 4'b0101;
    expect_next("load_5", 4'b0101, 1'b0, 1'b1);
    mode = MODE_UP;
    expect_next("up_6", 4'b0110, 1'b0, 1'b1);

    // Let the count advance once more, then reset between edges.
    @(posedge clk); #2;
    rst = 1'b1;
    e.casc = 1'b0; e.cyc = cyc; e.q = 8'h0A; e.tc = 1'b0; e.chg = 1'b0; e.name = "async_rst";
    sb.push_back(e);
    @(negedge clk); #1;
    rst = 1'b0;
    expect_next("rst_resume", 4'b1011, 1'b0, 1'b1);
    expect_next("rst_resume2", 4'b1100, 1'b0, 1'b1);

    c_rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      e.casc = 1'b1; e.cyc = cyc + 1; e.q = 8'(n); e.tc = 1'b0; e.chg = 1'b0; e.name = "cascade";
      sb.push_back(e);
      @(negedge clk); #1;
    end

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_reg_counter.md
# jk_reg_counter

Parametrised bank of WIDTH JK flip-flops with per-bit J/K control, a shared enable, and three extra modes built on the same cells: synchronous up-count, synchronous down-count and parallel load. It succeeds the single-bit JK flip-flop in the lab sequential-logic library and is the building block for the counter and shift labs that follow. The block also provides a terminal-count flag and a registered change indicator.

## Interface
- WIDTH, 8: number of JK cells; must be at least 2.
- RST_VAL, {WIDTH{1'b0}}: value loaded into Q on reset.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  global enable; 0 means every cell holds.
- mode  input  2  operation select: 00 JK, 01 UP, 10 DOWN, 11 LOAD.
- J  input  WIDTH  per-bit J; used in JK mode only.
- K  input  WIDTH  per-bit K; used in JK mode only.
- d  input  WIDTH  parallel load data; used in LOAD mode only.
- Q  output  WIDTH  cell state.
- Qbar  output  WIDTH  always ~Q (combinational).
- tc  output  1  terminal count (combinational).
- chg  output  1  registered; 1 for one cycle after any Q bit changed.

## Operation
- Reset: Q = RST_VAL, Qbar = ~RST_VAL, chg = 0. tc follows its equation from the reset Q.
- en = 0: Q holds regardless of mode, J, K and d. chg goes to 0 at the next edge.
- JK (00): per bit i, the J[i]K[i] pair acts as follows.
  - 00 holds.
  - 01 clears.
  - 10 sets.
  - 11 toggles.
- UP (01): each cell is driven with J = K = T[i].
  - T[0] = 1.
  - T[i] = &Q[i-1:0].
  - Q advances by 1 modulo 2^WIDTH; all-ones wraps to 0.
- DOWN (10): same structure with T[i] = &~Q[i-1:0].
  - Q decrements by 1 modulo 2^WIDTH; 0 wraps to all-ones.
- LOAD (11): Q <= d.
  - Implemented per bit as J = d[i], K = ~d[i].
  - J and K inputs are ignored.
- Counting must use the JK toggle path. A behavioural +1/-1 adder on Q is not permitted.
- tc = en & ((mode == UP & Q == all-ones) | (mode == DOWN & Q == 0)). tc is 0 in the JK and LOAD modes.
- chg <= en & (Q_next != Q). Loading the current value, or a JK hold pattern, gives chg = 0.

## Timing
- Latency: one cycle. Inputs sampled at rising edge n appear on Q after edge n.
- Qbar and tc are combinational from Q, en and mode. They have no extra latency.
- chg is high during the cycle immediately after the edge at which Q changed.
- rst rising mid-operation forces Q to RST_VAL and chg to 0 immediately, without waiting for a clock edge. It overrides en and mode.
- rst deasserted: the first rising edge at which rst is low performs a normal update.
- A mode change takes effect at the next edge. There is no pipeline or state to flush.
- tc is valid in the same cycle as the wrapping edge's inputs. Cascading a second block's en from tc therefore gives a synchronous 2·WIDTH counter.

## Structure
- Shared package jk_pkg holds the following:
  - localparams MODE_JK = 2'b00, MODE_UP = 2'b01, MODE_DN = 2'b10, MODE_LD = 2'b11.
  - The 2-bit jk_mode_t typedef.
- Sub-module jk_cell: one JK flip-flop with the following properties.
  - Ports clk, rst, ce, J, K, Q.
  - Parameter RV gives its reset value.
  - Async active-high reset.
  - Held when ce = 0.
- The top generates WIDTH jk_cell instances. It also contains the J/K steering mux per mode, the T-chain for UP/DOWN, the tc logic and the chg register.

## Test plan
- Reset and JK mode, WIDTH = 4, RST_VAL = 4'b1010:
  - Assert rst -> Q = 1010, Qbar = 0101, chg = 0.
  - Release rst, JK mode, J = 0101, K = 1010 -> Q = 0101 after one edge, chg = 1 in the next cycle.
  - Apply J = K = 1111 twice -> Q goes 1010, then 0101.
- UP wrap: LOAD d = 1110, then UP for 3 edges -> Q = 1111, 0000, 0001.
  - tc = 1 only while Q = 1111.
  - chg = 1 throughout.
- DOWN wrap: LOAD 0001, then DOWN for 3 edges -> Q = 0000, 1111, 1110.
  - tc = 1 only while Q = 0000.
- Enable and no-change cases:
  - en = 0 in UP mode for 5 edges -> Q unchanged, tc = 0, chg = 0.
  - LOAD of d equal to the current Q -> chg = 0.
- Async reset mid-count: UP running at Q = 0110, assert rst between edges -> Q = RST_VAL before the next edge, chg = 0.
  - Deassert rst -> the count resumes from RST_VAL + 1 on the first edge.
- Cascade: two instances with the high instance's en = low instance's tc, both in UP mode, run 300 edges -> combined 8-bit value equals the edge count modulo 256 on every cycle.
